// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant
// and a one-entry registered response buffer per port.
module alu_share_arbiter #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_srca0,
  input  logic [31:0]      req_srca1,
  input  logic [31:0]      req_srcb0,
  input  logic [31:0]      req_srcb1,
  input  logic [3:0]       req_ctrl0,
  input  logic [3:0]       req_ctrl1,
  input  logic             req_ign0,
  input  logic             req_ign1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [31:0]      alu_srca,
  output logic [31:0]      alu_srcb,
  output logic [3:0]       alu_ctrl,
  output logic             alu_ign,
  input  logic [31:0]      alu_res,
  input  logic             alu_zero,
  input  logic             alu_exc,
  input  logic [4:0]       alu_exccode,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_res0,
  output logic [31:0]      rsp_res1,
  output logic             rsp_zero0,
  output logic             rsp_zero1,
  output logic             rsp_exc0,
  output logic             rsp_exc1,
  output logic [4:0]       rsp_code0,
  output logic [4:0]       rsp_code1,
  output logic [TAG_W-1:0] rsp_tag0,
  output logic [TAG_W-1:0] rsp_tag1
);

  logic [1:0] elig;
  logic [1:0] grant;
  logic       rr_ptr;

  // A full buffer being drained this cycle still lets its port issue.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) begin
        grant = (RR_EN && rr_ptr) ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;

  // Operand mux: port 0 drives the ALU unless port 1 holds the grant.
  always_comb begin
    alu_srca = req_srca0;
    alu_srcb = req_srcb0;
    alu_ctrl = req_ctrl0;
    alu_ign  = req_ign0;
    if (grant[1]) begin
      alu_srca = req_srca1;
      alu_srcb = req_srcb1;
      alu_ctrl = req_ctrl1;
      alu_ign  = req_ign1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|grant) begin
      rr_ptr <= ~grant[1];
    end
  end

  // Response buffers: a reload on the same edge as a pop keeps the entry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      rsp_res0  <= '0;
      rsp_zero0 <= 1'b0;
      rsp_exc0  <= 1'b0;
      rsp_code0 <= '0;
      rsp_tag0  <= '0;
      rsp_res1  <= '0;
      rsp_zero1 <= 1'b0;
      rsp_exc1  <= 1'b0;
      rsp_code1 <= '0;
      rsp_tag1  <= '0;
    end else begin
      if (grant[0]) begin
        rsp_valid[0] <= 1'b1;
        rsp_res0     <= alu_res;
        rsp_zero0    <= alu_zero;
        rsp_exc0     <= alu_exc;
        rsp_code0    <= alu_exccode;
        rsp_tag0     <= req_tag0;
      end else if (rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end
      if (grant[1]) begin
        rsp_valid[1] <= 1'b1;
        rsp_res1     <= alu_res;
        rsp_zero1    <= alu_zero;
        rsp_exc1     <= alu_exc;
        rsp_code1    <= alu_exccode;
        rsp_tag1     <= req_tag1;
      end else if (rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model of the two buffers.
module tb_alu_share_arbiter;

  localparam int unsigned TAG_W = 4;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [4:0] EXC_OV  = 5'd12;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, rsp_ready;
  logic [31:0] srca0, srca1, srcb0, srcb1;
  logic [3:0] ctrl0, ctrl1;
  logic ign0, ign1;
  logic [TAG_W-1:0] tag0, tag1;

  // DUT A: round robin
  logic [1:0] a_req_ready, a_rsp_valid;
  logic [31:0] a_alu_srca, a_alu_srcb, a_alu_res;
  logic [3:0] a_alu_ctrl;
  logic a_alu_ign, a_alu_zero, a_alu_exc;
  logic [4:0] a_alu_code;
  logic [31:0] a_res0, a_res1;
  logic a_zero0, a_zero1, a_exc0, a_exc1;
  logic [4:0] a_code0, a_code1;
  logic [TAG_W-1:0] a_tag0, a_tag1;

  // DUT B: fixed priority
  logic [1:0] b_req_ready, b_rsp_valid;
  logic [31:0] b_alu_srca, b_alu_srcb, b_alu_res;
  logic [3:0] b_alu_ctrl;
  logic b_alu_ign, b_alu_zero, b_alu_exc;
  logic [4:0] b_alu_code;
  logic [31:0] b_res0, b_res1;
  logic b_zero0, b_zero1, b_exc0, b_exc1;
  logic [4:0] b_code0, b_code1;
  logic [TAG_W-1:0] b_tag0, b_tag1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: {res, zero, exc, code}
  function automatic logic [38:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c, input logic ign);
    logic [31:0] r;
    logic ov;
    ov = 1'b0;
    case (c)
      ALU_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a;
    endcase
    ov = ov && !ign;
    return {r, (r == 32'd0), ov, (ov ? EXC_OV : 5'd0)};
  endfunction

  assign {a_alu_res, a_alu_zero, a_alu_exc, a_alu_code} = alu_f(a_alu_srca, a_alu_srcb, a_alu_ctrl, a_alu_ign);
  assign {b_alu_res, b_alu_zero, b_alu_exc, b_alu_code} = alu_f(b_alu_srca, b_alu_srcb, b_alu_ctrl, b_alu_ign);

  alu_share_arbiter #(.RR_EN(1'b1), .TAG_W(TAG_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_srca0(srca0), .req_srca1(srca1), .req_srcb0(srcb0), .req_srcb1(srcb1),
    .req_ctrl0(ctrl0), .req_ctrl1(ctrl1), .req_ign0(ign0), .req_ign1(ign1),
    .req_tag0(tag0), .req_tag1(tag1),
    .alu_srca(a_alu_srca), .alu_srcb(a_alu_srcb), .alu_ctrl(a_alu_ctrl), .alu_ign(a_alu_ign),
    .alu_res(a_alu_res), .alu_zero(a_alu_zero), .alu_exc(a_alu_exc), .alu_exccode(a_alu_code),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res0(a_res0), .rsp_res1(a_res1), .rsp_zero0(a_zero0), .rsp_zero1(a_zero1),
    .rsp_exc0(a_exc0), .rsp_exc1(a_exc1), .rsp_code0(a_code0), .rsp_code1(a_code1),
    .rsp_tag0(a_tag0), .rsp_tag1(a_tag1)
  );

  alu_share_arbiter #(.RR_EN(1'b0), .TAG_W(TAG_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_srca0(srca0), .req_srca1(srca1), .req_srcb0(srcb0), .req_srcb1(srcb1),
    .req_ctrl0(ctrl0), .req_ctrl1(ctrl1), .req_ign0(ign0), .req_ign1(ign1),
    .req_tag0(tag0), .req_tag1(tag1),
    .alu_srca(b_alu_srca), .alu_srcb(b_alu_srcb), .alu_ctrl(b_alu_ctrl), .alu_ign(b_alu_ign),
    .alu_res(b_alu_res), .alu_zero(b_alu_zero), .alu_exc(b_alu_exc), .alu_exccode(b_alu_code),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res0(b_res0), .rsp_res1(b_res1), .rsp_zero0(b_zero0), .rsp_zero1(b_zero1),
    .rsp_exc0(b_exc0), .rsp_exc1(b_exc1), .rsp_code0(b_code0), .rsp_code1(b_code1),
    .rsp_tag0(b_tag0), .rsp_tag1(b_tag1)
  );

  // Transaction-level model of DUT A: per-port entry occupancy plus last winner.
  logic [1:0]       m_vld;
  logic [38:0]      m_dat [2];
  logic [TAG_W-1:0] m_tag [2];
  int               m_last;

  function automatic logic [1:0] exp_grant();
    bit e0, e1;
    e0 = req_valid[0] && (!m_vld[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_vld[1] || rsp_ready[1]);
    if (e0 && e1) return (m_last == 0) ? 2'b10 : 2'b01;
    return {e1, e0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_vld = 2'b00;
      m_last = 1;
      for (int i = 0; i < 2; i++) begin
        m_dat[i] = '0;
        m_tag[i] = '0;
      end
    end else begin
      g = exp_grant();
      if (g[0]) begin
        m_vld[0] = 1'b1; m_dat[0] = alu_f(srca0, srcb0, ctrl0, ign0); m_tag[0] = tag0; m_last = 0;
      end else if (rsp_ready[0]) m_vld[0] = 1'b0;
      if (g[1]) begin
        m_vld[1] = 1'b1; m_dat[1] = alu_f(srca1, srcb1, ctrl1, ign1); m_tag[1] = tag1; m_last = 1;
      end else if (rsp_ready[1]) m_vld[1] = 1'b0;
    end
  end

  task automatic idle(input int n);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    srca0 = 32'd1; srcb0 = 32'd2; ctrl0 = ALU_ADD; ign0 = 1'b0; tag0 = 4'd1;
    srca1 = 32'd3; srcb1 = 32'd4; ctrl1 = ALU_ADD; ign1 = 1'b0; tag1 = 4'd2;
    repeat (2) @(negedge clk);
    checks++; if (a_req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", a_req_ready); end
    checks++; if (a_rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", a_rsp_valid); end
    checks++; if ({a_res0, a_res1, a_tag0, a_code1} !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0", a_res0, a_res1); end
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    #1;
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", a_req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    idle(2);
    req_valid = 2'b01; srca0 = 32'd5; srcb0 = 32'd7; ctrl0 = ALU_ADD; ign0 = 1'b0; tag0 = 4'd3;
    rsp_ready = 2'b00;
    #1;
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", a_req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (a_rsp_valid !== 2'b01) begin errors++; $display("FAIL single_valid got %b want 01", a_rsp_valid); end
    checks++; if (a_res0 !== 32'd12 || a_zero0 !== 1'b0 || a_tag0 !== 4'd3) begin
      errors++; $display("FAIL single_data got res=%0d zero=%b tag=%0d want 12 0 3", a_res0, a_zero0, a_tag0);
    end
    @(negedge clk);
    checks++; if (a_rsp_valid[0] !== 1'b1 || a_res0 !== 32'd12) begin
      errors++; $display("FAIL single_hold got v=%b res=%0d want 1 12", a_rsp_valid[0], a_res0);
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (a_req_ready !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", k, a_req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      checks++; if (b_req_ready !== 2'b01) begin
        errors++; $display("FAIL fixed_grant%0d got %b want 01", k, b_req_ready);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    idle(2);
    req_valid = 2'b01; srca0 = 32'd1; srcb0 = 32'd2; ctrl0 = ALU_ADD; tag0 = 4'd5;
    rsp_ready = 2'b00;
    @(negedge clk);
    req_valid = 2'b11; srca1 = 32'd10; srcb1 = 32'd20; ctrl1 = ALU_ADD; ign1 = 1'b0; tag1 = 4'd7;
    rsp_ready = 2'b10;
    #1;
    checks++; if (a_req_ready !== 2'b10) begin errors++; $display("FAIL bp_blocked got %b want 10", a_req_ready); end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 2'b11 || a_res1 !== 32'd30 || a_res0 !== 32'd3) begin
      errors++; $display("FAIL bp_served got v=%b r1=%0d r0=%0d want 11 30 3", a_rsp_valid, a_res1, a_res0);
    end
    req_valid = 2'b01; srca0 = 32'd100; srcb0 = 32'd1; tag0 = 4'd6;
    rsp_ready = 2'b01;
    #1;
    checks++; if (a_req_ready !== 2'b01) begin errors++; $display("FAIL bp_release got %b want 01", a_req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (a_rsp_valid !== 2'b11 || a_res0 !== 32'd101 || a_tag0 !== 4'd6) begin
      errors++; $display("FAIL bp_reload got v=%b r0=%0d tag=%0d want 11 101 6", a_rsp_valid, a_res0, a_tag0);
    end
  endtask

  task automatic test_overflow();
    idle(2);
    req_valid = 2'b10; srca1 = 32'h7FFF_FFFF; srcb1 = 32'd1; ctrl1 = ALU_ADD; ign1 = 1'b0; tag1 = 4'd9;
    rsp_ready = 2'b00;
    @(negedge clk);
    checks++; if (a_exc1 !== 1'b1 || a_code1 !== EXC_OV || a_res1 !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_exc got exc=%b code=%0d res=%h want 1 %0d 80000000", a_exc1, a_code1, a_res1, EXC_OV);
    end
    ign1 = 1'b1;
    rsp_ready = 2'b10;
    #1;
    checks++; if (a_req_ready !== 2'b10) begin errors++; $display("FAIL ovf_pop_issue got %b want 10", a_req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (a_rsp_valid[1] !== 1'b1 || a_exc1 !== 1'b0 || a_code1 !== 5'd0 || a_res1 !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_ign got v=%b exc=%b code=%0d res=%h want 1 0 0 80000000", a_rsp_valid[1], a_exc1, a_code1, a_res1);
    end
  endtask

  task automatic test_midop_reset();
    idle(2);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (a_rsp_valid !== 2'b11) begin errors++; $display("FAIL midrst_full got %b want 11", a_rsp_valid); end
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 2'b00 || a_res0 !== 32'd0 || a_res1 !== 32'd0 || a_tag1 !== '0) begin
      errors++; $display("FAIL midrst_clear got v=%b r0=%h r1=%h want 00 0 0", a_rsp_valid, a_res0, a_res1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic [38:0] act [2];
    logic [TAG_W-1:0] atag [2];
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      act[0] = {a_res0, a_zero0, a_exc0, a_code0}; atag[0] = a_tag0;
      act[1] = {a_res1, a_zero1, a_exc1, a_code1}; atag[1] = a_tag1;
      checks++; if (a_rsp_valid !== m_vld) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, a_rsp_valid, m_vld);
      end
      for (int i = 0; i < 2; i++) begin
        if (m_vld[i]) begin
          checks++; if (act[i] !== m_dat[i] || atag[i] !== m_tag[i]) begin
            errors++; $display("FAIL rnd_data%0d cyc %0d got %h/%h want %h/%h", i, n, act[i], atag[i], m_dat[i], m_tag[i]);
          end
        end
      end
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      srca0 = ($urandom_range(3) == 0) ? 32'h7FFF_FFFF : $urandom;
      srca1 = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
      srcb0 = ($urandom_range(3) == 0) ? 32'd1 : $urandom;
      srcb1 = ($urandom_range(3) == 0) ? 32'd1 : $urandom;
      ctrl0 = 4'($urandom_range(6)); ctrl1 = 4'($urandom_range(6));
      ign0 = 1'($urandom); ign1 = 1'($urandom);
      tag0 = TAG_W'($urandom); tag1 = TAG_W'($urandom);
      #1;
      g = exp_grant();
      checks++; if (a_req_ready !== g) begin
        errors++; $display("FAIL rnd_grant cyc %0d got %b want %b", n, a_req_ready, g);
      end
      checks++; if (a_alu_srca !== (g[1] ? srca1 : srca0) || a_alu_ctrl !== (g[1] ? ctrl1 : ctrl0)) begin
        errors++; $display("FAIL rnd_alu_mux cyc %0d got %h/%0d", n, a_alu_srca, a_alu_ctrl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_midop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
